// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register addresses, exception codes, exc_in bit indices,
// exception vector, and the decoded-exception record handed from cp0_exc_prio.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int EXB_SYS   = 0;
    localparam int EXB_BRK   = 1;
    localparam int EXB_ERET  = 2;
    localparam int EXB_OV    = 3;
    localparam int EXB_ADE_D = 4;
    localparam int EXB_ADE_F = 5;
    localparam int EXB_RI    = 6;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        BADV_NONE = 2'd0,
        BADV_PC   = 2'd1,
        BADV_DATA = 2'd2
    } badv_sel_e;

    typedef struct packed {
        logic      take;
        logic      eret;
        logic [4:0] exccode;
        badv_sel_e badv_sel;
    } exc_dec_t;

    // Status image: BEV is hard-wired to 1, only IM/EXL/IE are stored.
    function automatic logic [31:0] status_read(input logic [7:0] im, input logic exl, input logic ie);
        return {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    endfunction

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational exception prioritiser: picks the winning exception (or eret)
// for the instruction in EX and says where BadVAddr should be loaded from.
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic [6:0] i_exc,
    input  logic       i_int_pending,
    input  logic       i_store,
    output exc_dec_t   o_dec
);

    // Fixed-priority decode, interrupt highest, eret only when nothing else fires.
    always_comb begin
        o_dec = '{take: 1'b0, eret: 1'b0, exccode: EXC_INT, badv_sel: BADV_NONE};
        if (i_int_pending) begin
            o_dec.take    = 1'b1;
            o_dec.exccode = EXC_INT;
        end else if (i_exc[EXB_ADE_F]) begin
            o_dec.take     = 1'b1;
            o_dec.exccode  = EXC_ADEL;
            o_dec.badv_sel = BADV_PC;
        end else if (i_exc[EXB_RI]) begin
            o_dec.take    = 1'b1;
            o_dec.exccode = EXC_RI;
        end else if (i_exc[EXB_OV]) begin
            o_dec.take    = 1'b1;
            o_dec.exccode = EXC_OV;
        end else if (i_exc[EXB_SYS]) begin
            o_dec.take    = 1'b1;
            o_dec.exccode = EXC_SYS;
        end else if (i_exc[EXB_BRK]) begin
            o_dec.take    = 1'b1;
            o_dec.exccode = EXC_BP;
        end else if (i_exc[EXB_ADE_D]) begin
            o_dec.take     = 1'b1;
            o_dec.exccode  = i_store ? EXC_ADES : EXC_ADEL;
            o_dec.badv_sel = BADV_DATA;
        end else if (i_exc[EXB_ERET]) begin
            o_dec.eret = 1'b1;
        end else begin
            o_dec.take = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: Status/Cause/EPC/BadVAddr/Count/Compare, timer interrupt,
// exception entry and eret redirect.
module cp0_reg
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] exc_in,
    input  logic [31:0] pc_in,
    input  logic        in_delayslot,
    input  logic [31:0] bad_addr_in,
    input  logic        store_in,
    input  logic [5:0]  ext_int,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    output logic        flush,
    output logic [31:0] exc_pc,
    output logic [31:0] epc_out,
    output logic        timer_int
);

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_int;
    logic        r_tick;

    logic        w_int_pending;
    exc_dec_t    w_dec;
    logic        w_take;
    logic        w_eret;
    logic        w_wr;
    logic        w_unused;

    assign w_unused      = ^exc_in[31:7];
    assign w_int_pending = r_ie & ~r_exl & (|({r_ip_hw, r_ip_sw} & r_im));

    cp0_exc_prio u_prio (
        .i_exc         (exc_in[6:0]),
        .i_int_pending (w_int_pending),
        .i_store       (store_in),
        .o_dec         (w_dec)
    );

    // Reset masks the redirect; an exception or eret drops a same-cycle mtc0.
    assign w_take = resetn & w_dec.take;
    assign w_eret = resetn & w_dec.eret;
    assign w_wr   = resetn & we & ~w_take & ~w_eret;

    assign flush     = w_take | w_eret;
    assign epc_out   = r_epc;
    assign timer_int = r_timer_int;

    // Redirect target selection.
    always_comb begin
        if (w_take) begin
            exc_pc = EXC_VECTOR;
        end else if (w_eret) begin
            exc_pc = r_epc;
        end else begin
            exc_pc = 32'h0;
        end
    end

    // mfc0 read mux, straight from register state.
    always_comb begin
        case (raddr)
            CP0_BADVADDR: rdata = r_badvaddr;
            CP0_COUNT:    rdata = r_count;
            CP0_COMPARE:  rdata = r_compare;
            CP0_STATUS:   rdata = status_read(r_im, r_exl, r_ie);
            CP0_CAUSE:    rdata = {r_bd, 15'b0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b0};
            CP0_EPC:      rdata = r_epc;
            default:      rdata = 32'h0;
        endcase
    end

    // Status, Cause, EPC and BadVAddr: exception entry, eret, then mtc0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_im       <= 8'h00;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_hw    <= 6'h00;
            r_ip_sw    <= 2'b00;
            r_exccode  <= 5'h00;
            r_epc      <= 32'h0;
            r_badvaddr <= 32'h0;
        end else begin
            r_ip_hw <= {r_timer_int | ext_int[5], ext_int[4:0]};
            if (w_take) begin
                r_exl     <= 1'b1;
                r_exccode <= w_dec.exccode;
                if (!r_exl) begin
                    r_epc <= in_delayslot ? (pc_in - 32'd4) : pc_in;
                    r_bd  <= in_delayslot;
                end
                case (w_dec.badv_sel)
                    BADV_PC:   r_badvaddr <= pc_in;
                    BADV_DATA: r_badvaddr <= bad_addr_in;
                    default:   r_badvaddr <= r_badvaddr;
                endcase
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end else if (w_wr) begin
                case (waddr)
                    CP0_STATUS: begin
                        r_im  <= wdata[15:8];
                        r_exl <= wdata[1];
                        r_ie  <= wdata[0];
                    end
                    CP0_CAUSE: r_ip_sw <= wdata[9:8];
                    CP0_EPC:   r_epc   <= wdata;
                    default:   r_epc   <= r_epc;
                endcase
            end
        end
    end

    // Count advances on every other clock; Compare match latches timer_int.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count     <= 32'h0;
            r_tick      <= 1'b0;
            r_compare   <= 32'h0;
            r_timer_int <= 1'b0;
        end else begin
            if (w_wr && (waddr == CP0_COUNT)) begin
                r_count <= wdata;
                r_tick  <= 1'b0;
            end else begin
                r_tick <= ~r_tick;
                if (r_tick) begin
                    r_count <= r_count + 32'd1;
                end
            end
            if (w_wr && (waddr == CP0_COMPARE)) begin
                r_compare   <= wdata;
                r_timer_int <= 1'b0;
            end else if (r_count == r_compare) begin
                r_timer_int <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_reg;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] exc_in;
    logic [31:0] pc_in;
    logic        in_delayslot;
    logic [31:0] bad_addr_in;
    logic        store_in;
    logic [5:0]  ext_int;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        flush;
    logic [31:0] exc_pc;
    logic [31:0] epc_out;
    logic        timer_int;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct packed {
        logic        flush;
        logic [31:0] pc;
        logic        crd;
        logic [31:0] rd;
        logic        cti;
        logic        ti;
        logic        cepc;
        logic [31:0] epc;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    failures = 0;
    logic  drv_valid = 1'b0;
    logic        nx_cti = 1'b0;
    logic        nx_ti = 1'b0;
    logic        nx_cepc = 1'b0;
    logic [31:0] nx_epc = 32'h0;

    cp0_reg dut (
        .clk(clk), .resetn(resetn), .exc_in(exc_in), .pc_in(pc_in),
        .in_delayslot(in_delayslot), .bad_addr_in(bad_addr_in), .store_in(store_in),
        .ext_int(ext_int), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(rdata), .flush(flush), .exc_pc(exc_pc), .epc_out(epc_out),
        .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp_v);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared at the falling edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            if (drv_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow actual=empty expected=entry");
                end else begin
                    e = q.pop_front();
                    n = nq.pop_front();
                    chk(n, "flush", {31'b0, flush}, {31'b0, e.flush});
                    chk(n, "exc_pc", exc_pc, e.pc);
                    if (e.crd)  chk(n, "rdata", rdata, e.rd);
                    if (e.cti)  chk(n, "timer_int", {31'b0, timer_int}, {31'b0, e.ti});
                    if (e.cepc) chk(n, "epc_out", epc_out, e.epc);
                end
            end
        end
    end

    task automatic step(input string nm, input logic rn, input logic [31:0] exc, input logic [31:0] pc,
                        input logic ds, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic ef, input logic [31:0] ep,
                        input logic crd, input logic [31:0] erd);
        exp_t e;
        resetn = rn; exc_in = exc; pc_in = pc; in_delayslot = ds;
        we = w; waddr = wa; wdata = wd; raddr = ra;
        e = '{flush: ef, pc: ep, crd: crd, rd: erd, cti: nx_cti, ti: nx_ti, cepc: nx_cepc, epc: nx_epc};
        q.push_back(e);
        nq.push_back(nm);
        nx_cti = 1'b0; nx_cepc = 1'b0;
        drv_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; exc_in = 32'h0; pc_in = 32'h0; in_delayslot = 1'b0;
        bad_addr_in = 32'h0; store_in = 1'b0; ext_int = 6'h00;
        we = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr = 5'd0;
        @(posedge clk);
        #1;
        // reset with a pending exception and write present
        step("rst0", 1'b0, 32'h1, 32'h100, 1'b0, 1'b1, 5'd12, 32'hFFFF, 5'd12, 1'b0, 32'h0, 1'b0, 32'h0);
        nx_cti = 1'b1; nx_ti = 1'b0;
        step("rst1", 1'b0, 32'h1, 32'h100, 1'b0, 1'b1, 5'd12, 32'hFFFF, 5'd12, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
        step("cmp_wr", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 5'd11, 32'hFFFF_FFFF, 5'd11, 1'b0, 32'h0, 1'b1, 32'h0);
        step("st_nobyp", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 5'd12, 32'h0000_FF01, 5'd12, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
        // syscall
        step("sys", 1'b1, 32'h1, 32'hBFC0_0100, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 1'b1, VEC, 1'b1, 32'h0040_FF01);
        nx_cepc = 1'b1; nx_epc = 32'hBFC0_0100;
        step("sys_epc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 32'h0, 1'b1, 32'hBFC0_0100);
        step("sys_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_0020);
        step("sys_exl", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 1'b0, 32'h0, 1'b1, 32'h0040_FF03);
        // overflow while EXL=1, then eret
        step("ov_exl", 1'b1, 32'h8, 32'h1000, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 1'b1, VEC, 1'b1, 32'hBFC0_0100);
        step("ov_epc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 32'h0, 1'b1, 32'hBFC0_0100);
        step("ov_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_0030);
        step("eret1", 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 1'b1, 32'hBFC0_0100, 1'b1, 32'h0040_FF03);
        step("eret1_exl", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 1'b0, 32'h0, 1'b1, 32'h0040_FF01);
        // fetch address error in delay slot
        step("adel_f", 1'b1, 32'h20, 32'h0040_0002, 1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 1'b1, VEC, 1'b1, 32'h0);
        step("adel_epc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 32'h0, 1'b1, 32'h003F_FFFE);
        step("adel_badv", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 1'b0, 32'h0, 1'b1, 32'h0040_0002);
        step("adel_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h8000_0010);
        step("eret2", 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 1'b1, 32'h003F_FFFE, 1'b1, 32'h0040_FF03);
        // break with a same-cycle mtc0 EPC
        step("bp_we", 1'b1, 32'h2, 32'h2000, 1'b0, 1'b1, 5'd14, 32'h1234, 5'd14, 1'b1, VEC, 1'b1, 32'h003F_FFFE);
        step("bp_epc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
        step("bp_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_0024);
        step("ri_sys", 1'b1, 32'h41, 32'h3000, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, VEC, 1'b1, 32'h0);
        step("ri_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_0028);
        step("ri_epc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
        // data address error on a store
        bad_addr_in = 32'hDEAD_0001; store_in = 1'b1;
        step("ades", 1'b1, 32'h10, 32'h3100, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, VEC, 1'b0, 32'h0);
        store_in = 1'b0;
        step("ades_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_0014);
        step("ades_badv", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 1'b0, 32'h0, 1'b1, 32'hDEAD_0001);
        step("eret3", 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 32'h0000_2000, 1'b0, 32'h0);
        // overflow beats eret in the same vector
        step("ov_eret", 1'b1, 32'hC, 32'h4000, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, VEC, 1'b0, 32'h0);
        step("ov2_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_0030);
        step("ov2_exl", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 1'b0, 32'h0, 1'b1, 32'h0040_FF03);
        step("eret4", 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 32'h0000_4000, 1'b0, 32'h0);
        // software interrupt through Cause.IP[9:8]
        step("ipsw_wr", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("swint", 1'b1, 32'h0, 32'h5000, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b1, VEC, 1'b1, 32'h0000_0330);
        step("swint_exl", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_0300);
        step("ipsw_clr", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 5'd13, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("ipsw_rd", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0);
        step("eret5", 1'b1, 32'h4, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, 32'h0000_5000, 1'b0, 32'h0);
        // timer: Compare=10, Count=0 -> match after 20 edges
        step("cmp10", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 5'd11, 32'd10, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("cnt0", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 5'd9, 32'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int n = 0; n < 22; n++) begin
            nx_cti = 1'b1; nx_ti = (n >= 21);
            step("count", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 1'b0, 32'h0, 1'b1, 32'(n / 2));
        end
        step("tmr_int", 1'b1, 32'h0, 32'h6000, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b1, VEC, 1'b0, 32'h0);
        step("tmr_cause", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0000_8000);
        nx_cti = 1'b1; nx_ti = 1'b1;
        step("tmr_clr", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 5'd11, 32'd10, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        nx_cti = 1'b1; nx_ti = 1'b0;
        step("tmr_low", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        nx_cepc = 1'b1; nx_epc = 32'h0000_6000;
        step("tmr_ip", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 1'b0, 32'h0, 1'b1, 32'h0);
        // reset during an exception cycle
        step("rst_exc", 1'b0, 32'h1, 32'h7000, 1'b0, 1'b1, 5'd14, 32'h55, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("rst_st", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
        step("rst_cnt", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 1'b0, 32'h0, 1'b1, 32'h0);
        nx_cepc = 1'b1; nx_epc = 32'h0;
        step("rst_epc", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd14, 1'b0, 32'h0, 1'b1, 32'h0);
        step("unimpl", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 1'b0, 32'h0, 1'b1, 32'h0);
        drv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
